// File: rtl/lc3_pkg.sv
// Shared definitions for the LC3 data-memory initiator:
// op codes, FSM state encodings and default widths.
package lc3_pkg;

    localparam int LC3_AW = 16;
    localparam int LC3_DW = 16;
    localparam int unsigned LC3_TIMEOUT = 15;

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_READ_IND  = 2'b10;
    localparam logic [1:0] OP_WRITE_IND = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_PTR_ACC  = 3'd1;
    localparam state_t S_PTR_WAIT = 3'd2;
    localparam state_t S_RD_ACC   = 3'd3;
    localparam state_t S_RD_WAIT  = 3'd4;
    localparam state_t S_WR_ACC   = 3'd5;
    localparam state_t S_WR_WAIT  = 3'd6;
    localparam state_t S_DONE     = 3'd7;

    function automatic logic op_is_ind(input logic [1:0] o);
        return o[1];
    endfunction

    function automatic logic op_is_wr(input logic [1:0] o);
        return o[0];
    endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Per-access wait counter; expired is raised once TIMEOUT
// stalled cycles have been counted (never when TIMEOUT is 0).
module lc3_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/lc3_dmem_initiator.sv
// LC3 data-memory initiator: runs one READ/WRITE/LDI/STI command
// on the Data_* bus and reports rdata or a timeout error.
module lc3_dmem_initiator
    import lc3_pkg::*;
#(
    parameter int AW = LC3_AW,
    parameter int DW = LC3_DW,
    parameter int unsigned TIMEOUT = LC3_TIMEOUT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          D_macc,
    output logic [AW-1:0] Data_addr,
    output logic [DW-1:0] Data_din,
    output logic          Data_rd,
    input  logic [DW-1:0] Data_dout,
    input  logic          complete_data
);

    state_t state;
    state_t next_state;

    logic [1:0]    op_q;
    logic [DW-1:0] wdata_q;

    logic          in_acc;
    logic          in_wait;
    logic          expired;
    logic          accept;

    logic          busy_n;
    logic          done_n;
    logic          err_n;
    logic [DW-1:0] rdata_n;
    logic          macc_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] din_n;
    logic          rd_n;

    assign accept  = (state == S_IDLE) && req;
    assign in_acc  = (state == S_PTR_ACC) || (state == S_RD_ACC)
                  || (state == S_WR_ACC);
    assign in_wait = (state == S_PTR_WAIT) || (state == S_RD_WAIT)
                  || (state == S_WR_WAIT);

    // Each ACC cycle re-arms the timer for the WAIT that follows.
    lc3_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (in_acc),
        .enable  (in_wait && !complete_data),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (op_is_ind(op)) begin
                        next_state = S_PTR_ACC;
                    end else if (op_is_wr(op)) begin
                        next_state = S_WR_ACC;
                    end else begin
                        next_state = S_RD_ACC;
                    end
                end
            end
            S_PTR_ACC: next_state = S_PTR_WAIT;
            S_PTR_WAIT: begin
                if (complete_data) begin
                    next_state = op_is_wr(op_q) ? S_WR_ACC : S_RD_ACC;
                end else if (expired) begin
                    next_state = S_DONE;
                end
            end
            S_RD_ACC: next_state = S_RD_WAIT;
            S_WR_ACC: next_state = S_WR_WAIT;
            S_RD_WAIT, S_WR_WAIT: begin
                if (complete_data || expired) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_n  = (next_state != S_IDLE);
        done_n  = (next_state == S_DONE);
        err_n   = done_n && in_wait && !complete_data;
        macc_n  = (next_state != S_IDLE) && (next_state != S_DONE);
        rd_n    = (next_state != S_WR_ACC);
        rdata_n = rdata;
        addr_n  = Data_addr;
        din_n   = Data_din;
        if (state == S_RD_WAIT && complete_data) begin
            rdata_n = Data_dout;
        end
        if (accept) begin
            addr_n = addr;
        end else if (state == S_PTR_WAIT && complete_data) begin
            addr_n = Data_dout;
        end
        if (next_state == S_WR_ACC) begin
            din_n = accept ? wdata : wdata_q;
        end
    end

    // Outputs are registered so complete_data never reaches the bus combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            D_macc    <= 1'b0;
            Data_addr <= '0;
            Data_din  <= '0;
            Data_rd   <= 1'b1;
            op_q      <= OP_READ;
            wdata_q   <= '0;
        end else begin
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            rdata     <= rdata_n;
            D_macc    <= macc_n;
            Data_addr <= addr_n;
            Data_din  <= din_n;
            Data_rd   <= rd_n;
            if (accept) begin
                op_q    <= op;
                wdata_q <= wdata;
            end
        end
    end

endmodule
